wb_queue: RTL and testbench

Writeback buffer sitting directly upstream of the 4×16-bit register file. It accepts register write requests (destination, data) from the execute/memory stages, holds up to DEPTH of them in order, and drains one per cycle into the register file write port (RegWrite/WR/WD). While writes are queued, it supplies bypass data for both register read ports so readers never see a stale value.

---
 rtl/wb_pkg.sv | 11 +
 rtl/wb_bypass_match.sv | 32 +++
 rtl/wb_queue.sv | 99 +++++++++
 tb/tb_wb_queue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and entry type for the writeback queue
package wb_pkg;
  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 2;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_bypass_match.sv
// rtl/wb_bypass_match.sv - newest-match search of queued writes for one read port
module wb_bypass_match
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  wb_entry_t         i_entries [DEPTH],
  input  logic [DEPTH-1:0]  i_valid,
  input  logic [PW-1:0]     i_head,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);
  logic [PW-1:0] w_idx;

  // Walk from head toward tail so a later (newer) match overrides an older one.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = i_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      if (i_valid[w_idx] && i_entries[w_idx].addr == i_rd_addr) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order writeback buffer ahead of the register file with read bypass
module wb_queue
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_reg,
  input  logic [DATA_W-1:0] push_data,
  input  logic              drain_en,
  input  logic [ADDR_W-1:0] RR1,
  input  logic [ADDR_W-1:0] RR2,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WR,
  output logic [DATA_W-1:0] WD,
  output logic              hit1,
  output logic              hit2,
  output logic [DATA_W-1:0] byp1,
  output logic [DATA_W-1:0] byp2,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_entry_t        r_entries [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_empty, w_full, w_pop, w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = drain_en & ~w_empty;
  assign w_push_ok = push & (~w_full | w_pop);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      // When full with a pop, tail equals head: the new valid bit must win.
      if (w_push_ok) begin
        r_entries[r_tail] <= '{addr: push_reg, data: push_data};
        r_valid[r_tail]   <= 1'b1;
        r_tail            <= r_tail + 1'b1;
      end
      if (w_push_ok && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push_ok)
        r_count <= r_count - 1'b1;
      if (push && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  assign RegWrite = w_pop;
  assign WR       = w_empty ? '0 : r_entries[r_head].addr;
  assign WD       = w_empty ? '0 : r_entries[r_head].data;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;

  wb_bypass_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_match1 (
    .i_entries (r_entries),
    .i_valid   (r_valid),
    .i_head    (r_head),
    .i_rd_addr (RR1),
    .o_hit     (hit1),
    .o_data    (byp1)
  );

  wb_bypass_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_match2 (
    .i_entries (r_entries),
    .i_valid   (r_valid),
    .i_head    (r_head),
    .i_rd_addr (RR2),
    .o_hit     (hit2),
    .o_data    (byp2)
  );
endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - scoreboard bench for wb_queue
module tb_wb_queue;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        push;
  logic [1:0]  push_reg;
  logic [15:0] push_data;
  logic        drain_en;
  logic [1:0]  RR1, RR2;
  logic        RegWrite;
  logic [1:0]  WR;
  logic [15:0] WD;
  logic        hit1, hit2;
  logic [15:0] byp1, byp2;
  logic [2:0]  count;
  logic        full, empty, overflow;

  typedef struct {
    logic [1:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   m_count = 0;
  bit   m_ovf   = 0;

  always #5 clock = ~clock;

  wb_queue dut (
    .clock(clock), .reset_n(reset_n), .push(push), .push_reg(push_reg),
    .push_data(push_data), .drain_en(drain_en), .RR1(RR1), .RR2(RR2),
    .RegWrite(RegWrite), .WR(WR), .WD(WD), .hit1(hit1), .hit2(hit2),
    .byp1(byp1), .byp2(byp2), .count(count), .full(full), .empty(empty),
    .overflow(overflow)
  );

  always @(negedge clock) begin
    if (RegWrite === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL drain_order: got write WR=%0h WD=%h, required no write", WR, WD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (WR !== e.a || WD !== e.d) begin
          errors++;
          $display("FAIL drain_order: got WR=%0h WD=%h, required WR=%0h WD=%h", WR, WD, e.a, e.d);
        end
      end
    end
  end

  task automatic cycle();
    bit pop, acc;
    pop = drain_en && (m_count > 0);
    acc = push && ((m_count < 4) || pop);
    @(posedge clock);
    if (!reset_n) begin
      sb.delete();
      m_count = 0;
      m_ovf   = 0;
    end else begin
      if (acc) sb.push_back('{a: push_reg, d: push_data});
      m_count = m_count + int'(acc) - int'(pop);
      if (push && !acc) m_ovf = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; push = 1'b0; push_reg = '0; push_data = '0;
    drain_en = 1'b0; RR1 = 2'd1; RR2 = 2'd2;
    cycle();
    cycle();
    reset_n  = 1'b1;
    drain_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (RegWrite !== 1'b0 || WR !== 2'd0 || WD !== 16'd0 || hit1 !== 1'b0 || hit2 !== 1'b0 ||
          byp1 !== 16'd0 || byp2 !== 16'd0 || count !== 3'd0 || empty !== 1'b1 ||
          full !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: got RegWrite=%b WR=%0h WD=%h hit=%b%b byp=%h/%h count=%0d empty=%b full=%b ovf=%b, required all idle",
                 RegWrite, WR, WD, hit1, hit2, byp1, byp2, count, empty, full, overflow);
      end
      cycle();
    end
  endtask

  task automatic test_single();
    drain_en = 1'b1; RR1 = 2'd1; RR2 = 2'd0;
    push = 1'b1; push_reg = 2'd1; push_data = 16'hAAAA;
    @(negedge clock);
    vectors++;
    if (hit1 !== 1'b0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL incoming_not_searched: got hit1=%b RegWrite=%b, required 0 0", hit1, RegWrite);
    end
    cycle();
    push = 1'b0;
    @(negedge clock);
    vectors++;
    if (RegWrite !== 1'b1 || WR !== 2'd1 || WD !== 16'hAAAA || hit1 !== 1'b1 || byp1 !== 16'hAAAA || hit2 !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got RegWrite=%b WR=%0h WD=%h hit1=%b byp1=%h hit2=%b, required 1 1 AAAA 1 AAAA 0",
               RegWrite, WR, WD, hit1, byp1, hit2);
    end
    cycle();
    @(negedge clock);
    vectors++;
    if (empty !== 1'b1 || hit1 !== 1'b0 || byp1 !== 16'd0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got empty=%b hit1=%b byp1=%h RegWrite=%b, required 1 0 0000 0",
               empty, hit1, byp1, RegWrite);
    end
  endtask

  task automatic test_fill_overflow();
    logic [1:0]  regs [4];
    logic [15:0] vals [4];
    regs = '{2'd1, 2'd2, 2'd1, 2'd3};
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_reg = regs[i]; push_data = vals[i];
      cycle();
    end
    push = 1'b0; RR1 = 2'd1; RR2 = 2'd3;
    @(negedge clock);
    vectors++;
    if (full !== 1'b1 || count !== 3'd4 || hit1 !== 1'b1 || byp1 !== 16'h3333 ||
        hit2 !== 1'b1 || byp2 !== 16'h4444 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL fill_bypass: got full=%b count=%0d hit1=%b byp1=%h hit2=%b byp2=%h RegWrite=%b, required 1 4 1 3333 1 4444 0",
               full, count, hit1, byp1, hit2, byp2, RegWrite);
    end
    RR1 = 2'd0; RR2 = 2'd2;
    @(posedge clock); #1;
    @(negedge clock);
    vectors++;
    if (hit1 !== 1'b0 || byp1 !== 16'd0 || hit2 !== 1'b1 || byp2 !== 16'h2222) begin
      errors++;
      $display("FAIL bypass_miss: got hit1=%b byp1=%h hit2=%b byp2=%h, required 0 0000 1 2222",
               hit1, byp1, hit2, byp2);
    end
    push = 1'b1; push_reg = 2'd0; push_data = 16'hDEAD;
    cycle();
    push = 1'b0;
    @(negedge clock);
    vectors++;
    if (overflow !== 1'b1 || count !== 3'd4 || m_ovf !== 1'b1 || m_count != 4) begin
      errors++;
      $display("FAIL overflow: got overflow=%b count=%0d, required 1 4", overflow, count);
    end
  endtask

  task automatic test_full_push_pop();
    drain_en = 1'b1;
    push = 1'b1; push_reg = 2'd2; push_data = 16'h5555;
    cycle();
    push = 1'b0; drain_en = 1'b0;
    @(negedge clock);
    vectors++;
    if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b1 || m_count != 4) begin
      errors++;
      $display("FAIL full_push_pop: got count=%0d full=%b overflow=%b, required 4 1 1", count, full, overflow);
    end
    drain_en = 1'b1;
    for (int i = 0; i < 20 && m_count > 0; i++) cycle();
    @(negedge clock);
    vectors++;
    if (empty !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL full_drain: got empty=%b pending=%0d, required 1 0", empty, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; push_reg = 2'($urandom_range(0, 3)); push_data = 16'($urandom);
      cycle();
      @(negedge clock);
      vectors++;
      if (count !== 3'd1 || RegWrite !== 1'b1) begin
        errors++;
        $display("FAIL stream_step%0d: got count=%0d RegWrite=%b, required 1 1", i, count, RegWrite);
      end
    end
    push = 1'b0;
    for (int i = 0; i < 10 && m_count > 0; i++) cycle();
    @(negedge clock);
    vectors++;
    if (empty !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_end: got empty=%b pending=%0d, required 1 0", empty, sb.size());
    end
  endtask

  task automatic test_mid_reset();
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_reg = 2'(i); push_data = 16'h7000 + 16'(i);
      cycle();
    end
    push = 1'b0; drain_en = 1'b1; reset_n = 1'b0;
    @(negedge clock);
    vectors++;
    if (RegWrite !== 1'b1 || WD !== 16'h7000 || count !== 3'd3) begin
      errors++;
      $display("FAIL reset_strobe: got RegWrite=%b WD=%h count=%0d, required 1 7000 3", RegWrite, WD, count);
    end
    cycle();
    reset_n = 1'b1; RR1 = 2'd1; RR2 = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if (empty !== 1'b1 || RegWrite !== 1'b0 || overflow !== 1'b0 || hit1 !== 1'b0 || hit2 !== 1'b0) begin
        errors++;
        $display("FAIL after_reset: got empty=%b RegWrite=%b overflow=%b hit=%b%b, required 1 0 0 00",
                 empty, RegWrite, overflow, hit1, hit2);
      end
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
